lin_interp_upsampler: RTL and testbench

- Converts a low-rate 28-bit sample stream (one sample per decimation period) back to full clock rate.
- Between consecutive input samples it emits L = 2^LOG2_L linearly interpolated outputs, one per enabled clock.
- Sits downstream of the boxcar averaging decimator on the Red Pitaya path, feeding DAC-rate logic.
- Uses a valid/ready input handshake with a one-entry lookahead buffer and reports an underrun flag.

---
 rtl/lin_interp_upsampler_pkg.sv | 20 ++
 rtl/lin_interp_upsampler_if.sv | 15 +
 rtl/lin_interp_upsampler_ramp.sv | 45 ++++
 rtl/lin_interp_upsampler.sv | 116 +++++++++++
 tb/tb_lin_interp_upsampler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/lin_interp_upsampler_pkg.sv
// Shared types and constants for the linear-interpolating upsampler.
package lin_interp_upsampler_pkg;

    localparam int DEFAULT_WIDTH = 28;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIME   = 2'd1,
        RUN     = 2'd2,
        STARVED = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/lin_interp_upsampler_if.sv
// Sample handshake bundle: low-rate input with valid/ready, full-rate output with valid.
interface lin_interp_upsampler_if
    import lin_interp_upsampler_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] signal_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] signal_out;
    logic             out_valid;

    modport master (output signal_in, in_valid, input in_ready, signal_out, out_valid);
    modport slave  (input signal_in, in_valid, output in_ready, signal_out, out_valid);
endinterface

// File: rtl/lin_interp_upsampler_ramp.sv
// interp_ramp_datapath: fixed-point ramp from a to b in 2^LOG2_L steps.
// acc carries one guard bit above a*L so full-scale swings never wrap.
module interp_ramp_datapath
    import lin_interp_upsampler_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int LOG2_L = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] ramp_o
);
    localparam int AW = WIDTH + LOG2_L + 1;

    logic [WIDTH:0]  delta_q, delta_d;
    logic [AW-1:0]   acc_q, acc_d;

    always_comb begin
        delta_d = delta_q;
        acc_d   = acc_q;
        if (load_i) begin
            delta_d = {b_i[WIDTH-1], b_i} - {a_i[WIDTH-1], a_i};
            acc_d   = {a_i[WIDTH-1], a_i, {LOG2_L{1'b0}}};
        end else if (step_i) begin
            acc_d = acc_q + {{LOG2_L{delta_q[WIDTH]}}, delta_q};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            delta_q <= '0;
            acc_q   <= '0;
        end else begin
            delta_q <= delta_d;
            acc_q   <= acc_d;
        end
    end

    // Dropping the low LOG2_L bits of a two's-complement value is floor division.
    assign ramp_o = acc_q[WIDTH+LOG2_L-1:LOG2_L];
endmodule

// File: rtl/lin_interp_upsampler.sv
// Linear-interpolating upsampler: L = 2^LOG2_L outputs per input segment,
// one-entry lookahead buffer, sticky underrun when a segment ends unfed.
module lin_interp_upsampler
    import lin_interp_upsampler_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int LOG2_L = 10
) (
    input  logic clock_in,
    input  logic reset,
    input  logic enable,
    input  logic clear_underrun,
    output logic underrun,
    lin_interp_upsampler_if.slave bus
);
    state_e            state_q;
    logic [WIDTH-1:0]  seg_b_q, x_next_q, signal_out_q;
    logic [LOG2_L-1:0] phase_q;
    logic              next_full_q, out_valid_q, underrun_q;

    logic              in_ready, accept, seg_end, have_next, load, step;
    logic [WIDTH-1:0]  new_b, ramp;

    assign in_ready  = reset && enable && !next_full_q;
    assign accept    = bus.in_valid && in_ready;
    assign seg_end   = (state_q == RUN) && (&phase_q);
    assign have_next = next_full_q || accept;
    // The buffer is always older than the sample on the bus, so it goes first.
    assign new_b     = next_full_q ? x_next_q : bus.signal_in;

    always_comb begin
        load = 1'b0;
        step = 1'b0;
        if (enable) begin
            case (state_q)
                PRIME, STARVED: load = accept;
                RUN: begin
                    load = seg_end && have_next;
                    step = !seg_end;
                end
                default: ;
            endcase
        end
    end

    interp_ramp_datapath #(.WIDTH(WIDTH), .LOG2_L(LOG2_L)) u_ramp (
        .clk_i  (clock_in),
        .rst_ni (reset),
        .load_i (load),
        .step_i (step),
        .a_i    (seg_b_q),
        .b_i    (new_b),
        .ramp_o (ramp)
    );

    always_ff @(posedge clock_in) begin
        if (!reset) begin
            state_q      <= IDLE;
            seg_b_q      <= '0;
            x_next_q     <= '0;
            next_full_q  <= 1'b0;
            phase_q      <= '0;
            signal_out_q <= '0;
            out_valid_q  <= 1'b0;
            underrun_q   <= 1'b0;
        end else if (!enable) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (clear_underrun) underrun_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    seg_b_q <= bus.signal_in;
                    state_q <= PRIME;
                end
                PRIME: if (accept) begin
                    seg_b_q <= bus.signal_in;
                    phase_q <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    signal_out_q <= ramp;
                    out_valid_q  <= 1'b1;
                    phase_q      <= phase_q + 1'b1;
                    if (accept) x_next_q <= bus.signal_in;
                    if (seg_end) begin
                        next_full_q <= next_full_q && accept;
                        if (have_next) begin
                            seg_b_q <= new_b;
                        end else begin
                            underrun_q <= 1'b1;
                            state_q    <= STARVED;
                        end
                    end else begin
                        next_full_q <= next_full_q || accept;
                    end
                end
                STARVED: begin
                    signal_out_q <= seg_b_q;
                    out_valid_q  <= 1'b1;
                    if (accept) begin
                        seg_b_q <= bus.signal_in;
                        phase_q <= '0;
                        state_q <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.signal_out = signal_out_q;
    assign bus.out_valid  = out_valid_q;
    assign underrun       = underrun_q;
endmodule

// File: tb/tb_lin_interp_upsampler.sv
// Scoreboard bench for lin_interp_upsampler at L=4: directed ramps plus a random stream.
module tb_lin_interp_upsampler;
    import lin_interp_upsampler_pkg::*;

    localparam int W  = 28;
    localparam int LG = 2;
    localparam int L  = 4;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, clr = 1'b0, underrun;

    lin_interp_upsampler_if #(.WIDTH(W)) bus ();

    lin_interp_upsampler #(.WIDTH(W), .LOG2_L(LG)) dut (
        .clock_in       (clk),
        .reset          (rst_n),
        .enable         (en),
        .clear_underrun (clr),
        .underrun       (underrun),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // hold=1 marks a starved hold value: matched once, then absorbs repeats.
    typedef struct { logic [W-1:0] val; bit hold; } exp_t;
    exp_t         exp_q[$];
    exp_t         mon_e;
    int           checks = 0, failures = 0;
    bit           holding = 1'b0;
    logic [W-1:0] hold_val;

    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (!(holding && bus.signal_out == hold_val)) begin
                holding = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_output got=%0d expected=none", $signed(bus.signal_out));
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.signal_out !== mon_e.val) begin
                        failures++;
                        $display("FAIL sample got=%0d expected=%0d", $signed(bus.signal_out), $signed(mon_e.val));
                    end
                    if (mon_e.hold) begin
                        holding  = 1'b1;
                        hold_val = mon_e.val;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic push(input longint v, input bit h);
        exp_t e;
        e.val  = v[W-1:0];
        e.hold = h;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] s);
        bit rdy;
        int n;
        n = 0;
        bus.signal_in = s;
        bus.in_valid  = 1'b1;
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 100);
        bus.in_valid = 1'b0;
        if (!rdy) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            idle(1);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        exp_q.delete();
        holding = 1'b0;
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] interp(input logic signed [W-1:0] a, b, input int k);
        longint v;
        v = longint'(a) * L + longint'(k) * (longint'(b) - longint'(a));
        v = v >>> LG;
        return v[W-1:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [W-1:0] prev, s;
        bit [31:0] r;
        bus.signal_in = '0;
        bus.in_valid  = 1'b0;
        prev = '0;

        idle(2);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_signal_out", bus.signal_out, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        do_reset();

        // Unit-slope ramp, buffer fill, underrun then clear.
        for (int k = 0; k < 12; k++) push(k, 0);
        push(12, 1);
        send(0);
        send(4);
        send(8);
        chk("in_ready_full", bus.in_ready, 0);
        send(12);
        drain();
        chk("underrun_set", underrun, 1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("underrun_clear", underrun, 0);

        // Falling ramp into a flat segment.
        do_reset();
        push(100, 0); push(50, 0); push(0, 0); push(-50, 0);
        for (int k = 0; k < 4; k++) push(-100, 0);
        push(-100, 1);
        send(100); send(-100); send(-100);
        drain();

        // Starve, hold, resume from the held value.
        do_reset();
        push(10, 0); push(12, 0); push(15, 0); push(17, 0);
        push(20, 0); push(22, 0); push(25, 0); push(27, 0);
        push(30, 1);
        send(10); send(20); send(30);
        drain();
        chk("starve_underrun", underrun, 1);
        idle(3);
        chk("starve_hold", $signed(bus.signal_out), 30);
        chk("starve_valid", bus.out_valid, 1);
        push(32, 0); push(35, 0); push(37, 0); push(40, 1);
        send(40);
        drain();
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("underrun_clear2", underrun, 0);

        // Full-scale swing, no wraparound.
        do_reset();
        push(134217727, 0); push(67108863, 0); push(-1, 0); push(-67108865, 0);
        push(-134217728, 1);
        send(28'sd134217727);
        send(-28'sd134217728);
        drain();
        chk("fs_underrun", underrun, 1);

        // Resume, then reset mid-segment.
        push(-100663296, 0); push(-67108864, 0); push(-33554432, 0); push(0, 1);
        send(0);
        idle(1);
        rst_n = 1'b0;
        idle(1);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_signal_out", bus.signal_out, 0);
        chk("midrst_underrun", underrun, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        idle(1);
        exp_q.delete();
        holding = 1'b0;
        rst_n = 1'b1;
        idle(1);

        // Random stream with short gaps and occasional enable drops.
        for (int i = 0; i < 1000; i++) begin
            r = $urandom();
            s = r[W-1:0];
            if (i > 0) for (int k = 0; k < L; k++) push(interp(prev, s, k), 0);
            if (i % 100 == 50) begin
                en = 1'b0;
                idle(5);
                en = 1'b1;
            end else begin
                idle($urandom_range(0, 2));
            end
            send(s);
            prev = s;
        end
        push(prev, 1);
        drain();
        chk("rand_no_underrun_before_end", underrun, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
